// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/acknowledge port of the MEM stage
interface mem_access_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_byte_enable;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_byte_enable, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_byte_enable, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: ALU pass-through, lane-steered loads/stores, misalignment trap
module mem_access #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      input_valid,
  output logic                      input_ready,
  output logic                      stall,
  input  logic                      input_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] input_write_addr,
  input  logic [31:0]               input_write_data,
  input  logic [3:0]                input_mem_op,
  input  logic [ADDR_WIDTH-1:0]     input_mem_addr,
  input  logic [31:0]               input_store_data,
  mem_access_if.master              mem,
  output logic                      output_valid,
  output logic                      write_enable,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]               write_data,
  output logic                      exception_misaligned
);
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t state, state_next;

  logic        dec_load, dec_store, dec_signed, dec_is_mem, dec_misaligned;
  size_t       dec_size;
  logic [1:0]  dec_lane;
  logic [3:0]  dec_byte_enable;
  logic [31:0] dec_wdata;
  logic [1:0]  offset;

  size_t       size_q, size_next;
  logic        signed_q, signed_next;
  logic [1:0]  lane_q, lane_next;
  logic [31:0] load_shifted, load_value;

  logic                      req_next, we_next, ov_next, exc_next, wen_next;
  logic [ADDR_WIDTH-1:0]     maddr_next;
  logic [3:0]                be_next;
  logic [31:0]               mwdata_next, wdata_next;
  logic [REG_ADDR_WIDTH-1:0] waddr_next;

  assign offset      = input_mem_addr[1:0];
  assign input_ready = (state == IDLE);
  assign stall       = !input_ready;

  // dec_lane is the lowest lane touched; enables and load shift both derive from it
  always_comb begin
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_signed = 1'b0;
    dec_size   = SZ_WORD;
    case (input_mem_op)
      4'd1:    begin dec_load  = 1'b1; dec_signed = 1'b1; dec_size = SZ_BYTE; end
      4'd2:    begin dec_load  = 1'b1; dec_size = SZ_BYTE; end
      4'd3:    begin dec_load  = 1'b1; dec_signed = 1'b1; dec_size = SZ_HALF; end
      4'd4:    begin dec_load  = 1'b1; dec_size = SZ_HALF; end
      4'd5:    begin dec_load  = 1'b1; end
      4'd8:    begin dec_store = 1'b1; dec_size = SZ_BYTE; end
      4'd9:    begin dec_store = 1'b1; dec_size = SZ_HALF; end
      4'd10:   begin dec_store = 1'b1; end
      default: ;
    endcase
    dec_is_mem     = dec_load | dec_store;
    dec_misaligned = dec_is_mem &&
                     (((dec_size == SZ_HALF) && offset[0]) ||
                      ((dec_size == SZ_WORD) && (offset != 2'b00)));
    case (dec_size)
      SZ_BYTE: begin
        dec_lane        = BIG_ENDIAN ? ~offset : offset;
        dec_byte_enable = 4'b0001 << dec_lane;
        dec_wdata       = {4{input_store_data[7:0]}};
      end
      SZ_HALF: begin
        dec_lane        = {(BIG_ENDIAN ? ~offset[1] : offset[1]), 1'b0};
        dec_byte_enable = 4'b0011 << dec_lane;
        dec_wdata       = {2{input_store_data[15:0]}};
      end
      default: begin
        dec_lane        = 2'b00;
        dec_byte_enable = 4'b1111;
        dec_wdata       = input_store_data;
      end
    endcase
  end

  always_comb begin
    load_shifted = mem.mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_value = {{24{signed_q & load_shifted[7]}}, load_shifted[7:0]};
      SZ_HALF: load_value = {{16{signed_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_value = load_shifted;
    endcase
  end

  always_comb begin
    state_next  = state;
    req_next    = mem.mem_req;
    we_next     = mem.mem_we;
    maddr_next  = mem.mem_addr;
    be_next     = mem.mem_byte_enable;
    mwdata_next = mem.mem_wdata;
    ov_next     = 1'b0;
    exc_next    = 1'b0;
    wen_next    = write_enable;
    waddr_next  = write_addr;
    wdata_next  = write_data;
    size_next   = size_q;
    signed_next = signed_q;
    lane_next   = lane_q;
    case (state)
      IDLE: begin
        if (input_valid) begin
          waddr_next = input_write_addr;
          if (!dec_is_mem) begin
            ov_next    = 1'b1;
            wen_next   = input_write_enable;
            wdata_next = input_write_data;
          end else if (dec_misaligned) begin
            ov_next    = 1'b1;
            exc_next   = 1'b1;
            wen_next   = 1'b0;
            wdata_next = 32'd0;
          end else begin
            state_next  = WAIT;
            req_next    = 1'b1;
            we_next     = dec_store;
            maddr_next  = {input_mem_addr[ADDR_WIDTH-1:2], 2'b00};
            be_next     = dec_byte_enable;
            mwdata_next = dec_wdata;
            wen_next    = input_write_enable & dec_load;
            size_next   = dec_size;
            signed_next = dec_signed;
            lane_next   = dec_lane;
          end
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
          ov_next    = 1'b1;
          wdata_next = mem.mem_we ? 32'd0 : load_value;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      mem.mem_req          <= 1'b0;
      mem.mem_we           <= 1'b0;
      mem.mem_addr         <= '0;
      mem.mem_byte_enable  <= 4'd0;
      mem.mem_wdata        <= 32'd0;
      output_valid         <= 1'b0;
      exception_misaligned <= 1'b0;
      write_enable         <= 1'b0;
      write_addr           <= '0;
      write_data           <= 32'd0;
      size_q               <= SZ_WORD;
      signed_q             <= 1'b0;
      lane_q               <= 2'b00;
    end else begin
      state                <= state_next;
      mem.mem_req          <= req_next;
      mem.mem_we           <= we_next;
      mem.mem_addr         <= maddr_next;
      mem.mem_byte_enable  <= be_next;
      mem.mem_wdata        <= mwdata_next;
      output_valid         <= ov_next;
      exception_misaligned <= exc_next;
      write_enable         <= wen_next;
      write_addr           <= waddr_next;
      write_data           <= wdata_next;
      size_q               <= size_next;
      signed_q             <= signed_next;
      lane_q               <= lane_next;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - big- and little-endian MEM stages driven in lockstep against a byte-level model
module tb_mem_access;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } stim_t;

  typedef struct {
    logic        is_mem;
    logic        misal;
    logic        mwe;
    logic [3:0]  be_b;
    logic [3:0]  be_l;
    logic [31:0] wdata;
    logic [31:0] data_b;
    logic [31:0] data_l;
    logic        wen;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clock, reset;
  logic        valid, we;
  logic [3:0]  op;
  logic [31:0] addr, sd, wd, rdata;
  logic [4:0]  wa;
  logic        ack;
  int          checks, errors;

  logic        rdy_b, rdy_l, stall_b, stall_l, ov_b, ov_l, wen_b, wen_l, exc_b, exc_l;
  logic [4:0]  wa_b, wa_l;
  logic [31:0] wd_b, wd_l;

  mem_access_if #(.ADDR_WIDTH(32)) if_b ();
  mem_access_if #(.ADDR_WIDTH(32)) if_l ();
  assign if_b.mem_ack   = ack;
  assign if_b.mem_rdata = rdata;
  assign if_l.mem_ack   = ack;
  assign if_l.mem_rdata = rdata;

  mem_access #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .BIG_ENDIAN(1'b1)) u_be (
    .clock(clock), .reset(reset), .input_valid(valid), .input_ready(rdy_b), .stall(stall_b),
    .input_write_enable(we), .input_write_addr(wa), .input_write_data(wd),
    .input_mem_op(op), .input_mem_addr(addr), .input_store_data(sd), .mem(if_b.master),
    .output_valid(ov_b), .write_enable(wen_b), .write_addr(wa_b), .write_data(wd_b),
    .exception_misaligned(exc_b)
  );

  mem_access #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .BIG_ENDIAN(1'b0)) u_le (
    .clock(clock), .reset(reset), .input_valid(valid), .input_ready(rdy_l), .stall(stall_l),
    .input_write_enable(we), .input_write_addr(wa), .input_write_data(wd),
    .input_mem_op(op), .input_mem_addr(addr), .input_store_data(sd), .mem(if_l.master),
    .output_valid(ov_l), .write_enable(wen_l), .write_addr(wa_l), .write_data(wd_l),
    .exception_misaligned(exc_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Byte j of the word lives at lane 3-j (big) or j (little); loads assemble bytes in address order.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int          n, k, j;
    bit          ld, sx;
    logic [31:0] vb, vl;
    n = 0; ld = 1'b0; sx = 1'b0;
    case (s.op)
      4'd1:  begin n = 1; ld = 1'b1; sx = 1'b1; end
      4'd2:  begin n = 1; ld = 1'b1; end
      4'd3:  begin n = 2; ld = 1'b1; sx = 1'b1; end
      4'd4:  begin n = 2; ld = 1'b1; end
      4'd5:  begin n = 4; ld = 1'b1; end
      4'd8:  n = 1;
      4'd9:  n = 2;
      4'd10: n = 4;
      default: n = 0;
    endcase
    e = '{default: '0};
    e.data_b = s.wd;
    e.data_l = s.wd;
    e.wen    = s.we;
    if (n == 0) return e;
    k = int'(s.addr[1:0]);
    if (k % n != 0) begin
      e.misal = 1'b1; e.data_b = 32'd0; e.data_l = 32'd0; e.wen = 1'b0;
      return e;
    end
    e.is_mem = 1'b1;
    e.mwe    = !ld;
    vb = 32'd0;
    vl = 32'd0;
    for (int i = 0; i < n; i++) begin
      j = k + i;
      e.be_b[3-j] = 1'b1;
      e.be_l[j]   = 1'b1;
      vb = (vb << 8) | ((s.rdata >> (8 * (3 - j))) & 32'hFF);
      vl = vl | (((s.rdata >> (8 * j)) & 32'hFF) << (8 * i));
    end
    if (sx && n < 4) begin
      if (vb[8*n-1]) vb = vb | ~((32'd1 << (8 * n)) - 32'd1);
      if (vl[8*n-1]) vl = vl | ~((32'd1 << (8 * n)) - 32'd1);
    end
    e.wdata  = (n == 1) ? {4{s.sd[7:0]}} : (n == 2) ? {2{s.sd[15:0]}} : s.sd;
    e.data_b = ld ? vb : 32'd0;
    e.data_l = ld ? vl : 32'd0;
    e.wen    = ld ? s.we : 1'b0;
    return e;
  endfunction

  task automatic check_mem(input stim_t s, input exp_t e);
    chk("req_be", if_b.mem_req, 1);
    chk("req_le", if_l.mem_req, 1);
    chk("mwe_be", if_b.mem_we, e.mwe);
    chk("mwe_le", if_l.mem_we, e.mwe);
    chk("maddr_be", if_b.mem_addr, s.addr & 32'hFFFF_FFFC);
    chk("maddr_le", if_l.mem_addr, s.addr & 32'hFFFF_FFFC);
    chk("ben_be", if_b.mem_byte_enable, e.be_b);
    chk("ben_le", if_l.mem_byte_enable, e.be_l);
    if (e.mwe) begin
      chk("mwdata_be", if_b.mem_wdata, e.wdata);
      chk("mwdata_le", if_l.mem_wdata, e.wdata);
    end
    chk("ready_busy", {rdy_b, rdy_l, stall_b, stall_l}, 4'b0011);
  endtask

  task automatic check_wb(input stim_t s, input exp_t e);
    chk("ov", {ov_b, ov_l}, 2'b11);
    chk("exc", {exc_b, exc_l}, {e.misal, e.misal});
    chk("wen", {wen_b, wen_l}, {e.wen, e.wen});
    chk("waddr_be", wa_b, s.wa);
    chk("waddr_le", wa_l, s.wa);
    chk("wdata_be", wd_b, e.data_b);
    chk("wdata_le", wd_l, e.data_l);
    chk("req_after", {if_b.mem_req, if_l.mem_req}, 2'b00);
    chk("ready_after", {rdy_b, rdy_l, stall_b, stall_l}, 4'b1100);
  endtask

  task automatic run_op(input stim_t s, input exp_t e);
    int low;
    chk("ready_before", {rdy_b, rdy_l}, 2'b11);
    valid = 1'b1; op = s.op; addr = s.addr; sd = s.sd; we = s.we; wa = s.wa; wd = s.wd;
    @(posedge clock); #1;
    valid = 1'b0;
    if (e.is_mem) begin
      check_mem(s, e);
      low = 0;
      for (int i = 0; i < s.waits; i++) begin
        if (!rdy_b) low++;
        @(posedge clock); #1;
      end
      if (!rdy_b) low++;
      check_mem(s, e);
      ack = 1'b1; rdata = s.rdata;
      @(posedge clock); #1;
      ack = 1'b0; rdata = $urandom;
      chk("ready_low_cycles", low, s.waits + 1);
    end else begin
      chk("no_req", {if_b.mem_req, if_l.mem_req}, 2'b00);
    end
    check_wb(s, e);
  endtask

  vec_t  vecs[13];
  stim_t rs;
  exp_t  re;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; valid = 1'b1; op = 4'd0; addr = 32'd0; sd = 32'd0;
    we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF; ack = 1'b0; rdata = 32'd0;

    vecs[0]  = '{'{4'd0,  32'h0,    32'h0,        32'h0,        0, 1'b1, 5'd5,  32'h12345678},
                 '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'h12345678, 32'h12345678, 1'b1}};
    vecs[1]  = '{'{4'd1,  32'h1001, 32'h0,        32'h00AA0000, 3, 1'b1, 5'd7,  32'h11111111},
                 '{1'b1, 1'b0, 1'b0, 4'b0100, 4'b0010, 32'h0, 32'hFFFFFFAA, 32'h00000000, 1'b1}};
    vecs[2]  = '{'{4'd9,  32'h2002, 32'h0000BEEF, 32'h0,        1, 1'b1, 5'd8,  32'h22222222},
                 '{1'b1, 1'b0, 1'b1, 4'b0011, 4'b1100, 32'hBEEFBEEF, 32'h0, 32'h0, 1'b0}};
    vecs[3]  = '{'{4'd5,  32'h3002, 32'h0,        32'h0,        0, 1'b1, 5'd9,  32'h00000055},
                 '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0}};
    vecs[4]  = '{'{4'd3,  32'h0002, 32'h0,        32'h80017F00, 2, 1'b1, 5'd10, 32'h0},
                 '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 32'h0, 32'h00007F00, 32'hFFFF8001, 1'b1}};
    vecs[5]  = '{'{4'd2,  32'h0003, 32'h0,        32'h12345680, 0, 1'b0, 5'd11, 32'h0},
                 '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b1000, 32'h0, 32'h00000080, 32'h00000012, 1'b0}};
    vecs[6]  = '{'{4'd8,  32'h0040, 32'hDEADBEA5, 32'h0,        0, 1'b1, 5'd12, 32'h0},
                 '{1'b1, 1'b0, 1'b1, 4'b1000, 4'b0001, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0}};
    vecs[7]  = '{'{4'd10, 32'h0044, 32'hCAFEF00D, 32'h0,        2, 1'b0, 5'd13, 32'h0},
                 '{1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0}};
    vecs[8]  = '{'{4'd5,  32'h0048, 32'h0,        32'h89ABCDEF, 1, 1'b1, 5'd31, 32'h0},
                 '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 32'h0, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1}};
    vecs[9]  = '{'{4'd9,  32'h0051, 32'h1234,     32'h0,        0, 1'b1, 5'd3,  32'h77777777},
                 '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0}};
    vecs[10] = '{'{4'd6,  32'h0001, 32'h0,        32'h0,        0, 1'b1, 5'd0,  32'hA5A55A5A},
                 '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'hA5A55A5A, 32'hA5A55A5A, 1'b1}};
    vecs[11] = '{'{4'd4,  32'h0003, 32'h0,        32'h0,        0, 1'b1, 5'd4,  32'h0},
                 '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0}};
    vecs[12] = '{'{4'd1,  32'h0002, 32'h0,        32'h00807F00, 1, 1'b1, 5'd14, 32'h0},
                 '{1'b1, 1'b0, 1'b0, 4'b0010, 4'b0100, 32'h0, 32'h0000007F, 32'hFFFFFF80, 1'b1}};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", {if_b.mem_req, if_l.mem_req, if_b.mem_we, if_l.mem_we}, 4'b0000);
    chk("rst_maddr", if_b.mem_addr | if_l.mem_addr, 32'd0);
    chk("rst_ben", {if_b.mem_byte_enable, if_l.mem_byte_enable}, 8'd0);
    chk("rst_mwdata", if_b.mem_wdata | if_l.mem_wdata, 32'd0);
    chk("rst_wb_flags", {ov_b, ov_l, wen_b, wen_l, exc_b, exc_l}, 6'd0);
    chk("rst_waddr", {wa_b, wa_l}, 10'd0);
    chk("rst_wdata", wd_b | wd_l, 32'd0);
    valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("ready_after_reset", {rdy_b, rdy_l}, 2'b11);

    for (int i = 0; i < 13; i++) run_op(vecs[i].s, vecs[i].e);

    @(posedge clock); #1;
    chk("ov_pulse_drops", {ov_b, ov_l, exc_b, exc_l}, 4'b0000);

    // Abort a load in flight, then confirm a stray ack in IDLE is ignored.
    valid = 1'b1; op = 4'd5; addr = 32'h10; we = 1'b1; wa = 5'd2;
    @(posedge clock); #1;
    valid = 1'b0;
    chk("abort_req_before", {if_b.mem_req, if_l.mem_req}, 2'b11);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("abort_req_async", {if_b.mem_req, if_l.mem_req}, 2'b00);
    #3;
    reset = 1'b1;
    ack = 1'b1; rdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    ack = 1'b0;
    chk("abort_no_ov", {ov_b, ov_l, if_b.mem_req, if_l.mem_req}, 4'b0000);
    @(posedge clock); #1;
    chk("abort_no_ov2", {ov_b, ov_l}, 2'b00);
    rs = '{4'd4, 32'h0, 32'h0, 32'h8001FFFF, 1, 1'b1, 5'd6, 32'h0};
    re = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0011, 32'h0, 32'h00008001, 32'h0000FFFF, 1'b1};
    run_op(rs, re);

    for (int i = 0; i < 150; i++) begin
      rs.op    = 4'($urandom_range(0, 15));
      rs.addr  = $urandom;
      rs.sd    = $urandom;
      rs.rdata = $urandom;
      rs.waits = $urandom_range(0, 3);
      rs.we    = 1'($urandom);
      rs.wa    = 5'($urandom);
      rs.wd    = $urandom;
      re = model(rs);
      run_op(rs, re);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
